tdm_demux: RTL and testbench
============================

Name: tdm_demux

Overview:
- Receive-side counterpart of the team's multiplexer blocks: takes a time-division-multiplexed serial bit stream and steers each slot's bit to its own channel.
- A frame sync marks slot 0. The block hunts for sync, locks to it, and assembles CHANNELS bits per frame in a shadow register.
- When a frame is complete, it presents all channel bits in parallel with a one-cycle frame strobe.
- Sits downstream of a serial link or TDM mux, feeding per-channel logic.

Parameters:
- CHANNELS, 8, number of TDM slots per frame (legal range 2..256).
- SEL_W, $clog2(CHANNELS), width of the slot index.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  bit-valid qualifier; d_in and sync_in are sampled only when en=1.
- d_in  input  1  serial data bit for the current slot.
- sync_in  input  1  frame-start marker; qualified by en, flags the bit on d_in as slot 0.
- ch_out  output  CHANNELS  parallel channel bits of the last completed frame; bit i = slot i.
- frame_valid  output  1  one-cycle pulse when ch_out updates.
- slot  output  SEL_W  slot index expected for the next qualified bit.
- locked  output  1  high in LOCKED state.
- sync_err  output  1  one-cycle pulse on unexpected sync.

Behaviour:
- Reset (synchronous, active-high, dominates every other input):
  - ch_out=0, frame_valid=0, sync_err=0, slot=0, locked=0.
  - Internal shadow register cleared; state=HUNT.
  - Reset mid-frame discards the partial frame. The next frame needs a fresh sync.
- States: HUNT, LOCKED. locked = (state==LOCKED), registered.
- HUNT:
  - en=1 with sync_in=0: bit discarded, slot stays 0.
  - en=1 with sync_in=1: shadow[0]<=d_in, other shadow bits cleared, slot<=1, state<=LOCKED. No frame_valid.
- LOCKED, en=1, sync_in=0:
  - shadow[slot]<=d_in.
  - If slot==CHANNELS-1: ch_out<=shadow with bit CHANNELS-1 replaced by d_in, frame_valid<=1, slot<=0. Otherwise slot<=slot+1.
- LOCKED, en=1, sync_in=1, slot==0: normal slot-0 bit, same as the sync_in=0 case. Sync is optional at slot 0; a free-running stream stays locked.
- LOCKED, en=1, sync_in=1, slot!=0 (misaligned sync):
  - sync_err<=1.
  - Partial frame discarded: shadow cleared, then shadow[0]<=d_in, slot<=1.
  - ch_out unchanged, frame_valid=0, stays LOCKED.
- en=0: all state, slot, shadow and ch_out hold. frame_valid=0 and sync_err=0 next cycle. sync_in and d_in are ignored.
- Latency: ch_out/frame_valid update on the clock edge that samples the last slot's bit. frame_valid is high for exactly the following cycle.
- Back-to-back frames (en held high) give frame_valid once every CHANNELS cycles. It is never high on consecutive cycles for CHANNELS>=2.
- ch_out holds its value between frames. It changes only together with frame_valid or on reset.
- frame_valid and sync_err are never asserted in the same cycle.
- slot wraps CHANNELS-1 -> 0 exactly. For non-power-of-two CHANNELS, slot never reaches values >= CHANNELS.

Test Plan:
- Reset then HUNT with CHANNELS=8: drive 5 bits with en=1, sync_in=0 -> locked=0, slot=0, frame_valid never asserts, ch_out=8'h00.
- Lock and first frame: sync_in=1 on first bit, en=1 for 8 cycles, d_in slot0..7 = 1,0,1,1,0,0,1,0 -> locked=1 after first edge; ch_out=8'b0100_1101 with a single-cycle frame_valid after the 8th bit.
- Gapped stream: same frame with en=0 inserted for 3 cycles after slot 3 -> slot holds at 4 during gap; identical ch_out=8'h4D; frame_valid delayed by 3 cycles.
- Misaligned sync: lock, send 3 bits, then sync_in=1 with d_in=1 -> sync_err pulses one cycle, slot=1. Then send 7 bits all 0 -> ch_out=8'h01, frame_valid once; the earlier partial frame never appears.
- Continuous frames: two back-to-back frames 8'hA5 then 8'h3C, sync only on the first -> frame_valid exactly 8 cycles apart; ch_out=8'hA5 then 8'h3C, held between pulses.
- Reset mid-frame: lock, send 5 bits, assert reset one cycle -> all outputs 0, locked=0. Bits without sync are then ignored until a new sync.

Source files
------------

// File: rtl/tdm_demux.sv
// TDM receive demultiplexer: hunts for frame sync, then steers each slot's
// serial bit into a shadow register and publishes whole frames in parallel.
module tdm_demux #(
  parameter int CHANNELS = 8,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                d_in,
  input  logic                sync_in,
  output logic [CHANNELS-1:0] ch_out,
  output logic                frame_valid,
  output logic [SEL_W-1:0]    slot,
  output logic                locked,
  output logic                sync_err
);

  typedef enum logic {HUNT, LOCKED} state_t;

  localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS - 1);

  state_t              state, state_n;
  logic [SEL_W-1:0]    slot_n;
  logic [CHANNELS-1:0] shadow, shadow_n, ch_n;
  logic                fv_n, se_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HUNT;
      slot        <= '0;
      shadow      <= '0;
      ch_out      <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      state       <= state_n;
      slot        <= slot_n;
      shadow      <= shadow_n;
      ch_out      <= ch_n;
      frame_valid <= fv_n;
      sync_err    <= se_n;
    end
  end

  assign locked = (state == LOCKED);

  always_comb begin
    state_n  = state;
    slot_n   = slot;
    shadow_n = shadow;
    ch_n     = ch_out;
    fv_n     = 1'b0;
    se_n     = 1'b0;
    if (en) begin
      unique case (state)
        HUNT: begin
          if (sync_in) begin
            shadow_n    = '0;
            shadow_n[0] = d_in;
            slot_n      = SEL_W'(1);
            state_n     = LOCKED;
          end
        end
        LOCKED: begin
          // Sync at slot 0 is just confirmation; anywhere else restarts the frame.
          if (sync_in && slot != '0) begin
            se_n        = 1'b1;
            shadow_n    = '0;
            shadow_n[0] = d_in;
            slot_n      = SEL_W'(1);
          end else begin
            shadow_n[slot] = d_in;
            if (slot == LAST) begin
              ch_n   = shadow_n;
              fv_n   = 1'b1;
              slot_n = '0;
            end else begin
              slot_n = slot + SEL_W'(1);
            end
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (CHANNELS=8): hunt, lock, gaps, misaligned
// sync, back-to-back frames and mid-frame reset.
module tb_tdm_demux;

  localparam int CHANNELS = 8;
  localparam int SEL_W    = 3;

  logic                clk = 1'b0;
  logic                reset, en, d_in, sync_in;
  logic [CHANNELS-1:0] ch_out;
  logic                frame_valid, locked, sync_err;
  logic [SEL_W-1:0]    slot;

  int checks = 0;
  int passed = 0;

  tdm_demux #(.CHANNELS(CHANNELS), .SEL_W(SEL_W)) dut (
    .clk(clk), .reset(reset), .en(en), .d_in(d_in), .sync_in(sync_in),
    .ch_out(ch_out), .frame_valid(frame_valid), .slot(slot),
    .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic e, input logic s, input logic d);
    en = e; sync_in = s; d_in = d;
    @(posedge clk); #1;
  endtask

  logic [15:0] two_frames;
  logic [7:0]  f1;

  initial begin
    reset = 1'b1; en = 1'b0; d_in = 1'b0; sync_in = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_ch", 32'(ch_out), 32'h0);
    chk("rst_fv", 32'(frame_valid), 32'h0);
    chk("rst_se", 32'(sync_err), 32'h0);
    chk("rst_slot", 32'(slot), 32'h0);
    chk("rst_lock", 32'(locked), 32'h0);

    // HUNT: unsynced bits are dropped
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, i[0]);
      chk("hunt_lock", 32'(locked), 32'h0);
      chk("hunt_slot", 32'(slot), 32'h0);
      chk("hunt_fv", 32'(frame_valid), 32'h0);
    end
    chk("hunt_ch", 32'(ch_out), 32'h0);

    // Lock and first frame: slots 1,0,1,1,0,0,1,0 -> 8'h4D
    f1 = 8'h4D;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, i == 0, f1[i]);
      chk("f1_lock", 32'(locked), 32'h1);
      chk("f1_fv", 32'(frame_valid), (i == 7) ? 32'h1 : 32'h0);
      chk("f1_slot", 32'(slot), (i == 7) ? 32'h0 : 32'(i + 1));
    end
    chk("f1_ch", 32'(ch_out), 32'h4D);
    step(1'b0, 1'b0, 1'b0);
    chk("f1_fv_pulse", 32'(frame_valid), 32'h0);
    chk("f1_ch_hold", 32'(ch_out), 32'h4D);

    // Gapped frame: 3 idle cycles after slot 3, inputs toggling while idle
    for (int i = 0; i < 4; i++) step(1'b1, i == 0, f1[i]);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, i[0]);
      chk("gap_slot", 32'(slot), 32'h4);
      chk("gap_fv", 32'(frame_valid), 32'h0);
      chk("gap_se", 32'(sync_err), 32'h0);
    end
    for (int i = 4; i < 8; i++) begin
      step(1'b1, 1'b0, f1[i]);
      chk("gap_fv2", 32'(frame_valid), (i == 7) ? 32'h1 : 32'h0);
    end
    chk("gap_ch", 32'(ch_out), 32'h4D);

    // Misaligned sync after 3 bits restarts the frame
    for (int i = 0; i < 3; i++) step(1'b1, i == 0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    chk("mis_se", 32'(sync_err), 32'h1);
    chk("mis_slot", 32'(slot), 32'h1);
    chk("mis_fv", 32'(frame_valid), 32'h0);
    chk("mis_ch_hold", 32'(ch_out), 32'h4D);
    chk("mis_lock", 32'(locked), 32'h1);
    for (int i = 1; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b0);
      chk("mis_se_pulse", 32'(sync_err), 32'h0);
      chk("mis_fv2", 32'(frame_valid), (i == 7) ? 32'h1 : 32'h0);
    end
    chk("mis_ch", 32'(ch_out), 32'h01);

    // Back-to-back frames A5 then 3C, sync only on the first
    two_frames = 16'h3CA5;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, i == 0, two_frames[i]);
      chk("b2b_fv", 32'(frame_valid), (i == 7 || i == 15) ? 32'h1 : 32'h0);
      chk("b2b_excl", 32'(frame_valid & sync_err), 32'h0);
      if (i < 7)       chk("b2b_ch_prev", 32'(ch_out), 32'h01);
      else if (i < 15) chk("b2b_ch_a5", 32'(ch_out), 32'hA5);
      else             chk("b2b_ch_3c", 32'(ch_out), 32'h3C);
    end

    // Reset mid-frame (with en high) discards everything
    for (int i = 0; i < 5; i++) step(1'b1, i == 0, 1'b1);
    chk("mid_slot_pre", 32'(slot), 32'h5);
    reset = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    reset = 1'b0;
    chk("mid_rst_ch", 32'(ch_out), 32'h0);
    chk("mid_rst_lock", 32'(locked), 32'h0);
    chk("mid_rst_slot", 32'(slot), 32'h0);
    chk("mid_rst_fv", 32'(frame_valid), 32'h0);
    chk("mid_rst_se", 32'(sync_err), 32'h0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b1);
      chk("mid_hunt_lock", 32'(locked), 32'h0);
      chk("mid_hunt_fv", 32'(frame_valid), 32'h0);
    end
    chk("mid_hunt_ch", 32'(ch_out), 32'h0);
    for (int i = 0; i < 8; i++) step(1'b1, i == 0, 1'b1);
    chk("mid_relock_fv", 32'(frame_valid), 32'h1);
    chk("mid_relock_ch", 32'(ch_out), 32'hFF);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
